// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter: round-robin sharing of the register bank write port among NREQ requesters.
// Optional feature macro REGBANK_R0_PROTECT_EN: grants that target register 0 still pulse gnt but keep wr low.
module regbank_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_dr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               wr,
  output logic [AW-1:0]      dr,
  output logic [DW-1:0]      wrData,
  output logic               busy
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr, win, nextPtr;
  logic [NREQ-1:0] elig;
  logic hasWin, wrNext;
  logic [AW-1:0] winDr;
  // The registered grant doubles as the mask, hiding a requester while it drops req.
  assign elig = req & ~gnt;
  assign busy = |elig;
  assign winDr = req_dr[win*AW +: AW];
  assign nextPtr = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
  // Pick the first eligible requester searching upward from ptr with wrap-around.
  always_comb begin
    hasWin = 1'b0;
    win = '0;
    for (int k = 0; k < NREQ; k++)
      if (!hasWin && elig[PW'((int'(ptr) + k) % NREQ)]) begin
        hasWin = 1'b1;
        win = PW'((int'(ptr) + k) % NREQ);
      end
  end
  // Decide whether the winning grant actually writes the bank.
  always_comb begin
`ifdef REGBANK_R0_PROTECT_EN
    wrNext = hasWin && (winDr != '0);
`else
    wrNext = hasWin;
`endif
  end
  // Register grant, write port and priority pointer; dr/wrData hold when idle.
  always_ff @(posedge clk)
    if (rst) begin
      gnt <= '0;
      wr <= 1'b0;
      dr <= '0;
      wrData <= '0;
      ptr <= '0;
    end else begin
      gnt <= hasWin ? NREQ'(1) << win : '0;
      wr <= wrNext;
      if (hasWin) begin
        dr <= winDr;
        wrData <= req_data[win*DW +: DW];
        ptr <= nextPtr;
      end
    end
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb_regbank_wr_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter/bank model.
module tb_regbank_wr_arbiter;
  localparam int NREQ = 4, AW = 5, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] reqDr = '0;
  logic [NREQ*DW-1:0] reqData = '0;
  logic [NREQ-1:0] gnt;
  logic wr, busy;
  logic [AW-1:0] dr;
  logic [DW-1:0] wrData;
  int errors = 0, checks = 0, pulses;
  bit run = 1'b0;
  logic [DW-1:0] bank [32];
  logic [DW-1:0] mBank [32];
  bit mWritten [32];
  int mPtr = 0;
  logic [NREQ-1:0] expGnt = '0;
  logic expWr = 1'b0;
  logic [AW-1:0] expDr = '0;
  logic [DW-1:0] expData = '0;

  regbank_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dr(reqDr), .req_data(reqData),
    .gnt(gnt), .wr(wr), .dr(dr), .wrData(wrData), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bank as seen by the DUT's write port.
  always @(posedge clk) if (wr) bank[dr] <= wrData;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the reference model across one rising edge using the current inputs.
  task automatic modelStep();
    int w = -1;
    if (expWr) begin
      mBank[expDr] = expData;
      mWritten[expDr] = 1'b1;
    end
    if (rst) begin
      mPtr = 0;
      expGnt = '0;
      expWr = 1'b0;
      expDr = '0;
      expData = '0;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(mPtr + k) % NREQ] && !expGnt[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
      expGnt = '0;
      expWr = 1'b0;
      if (w >= 0) begin
        expGnt[w] = 1'b1;
        expDr = reqDr[w*AW +: AW];
        expData = reqData[w*DW +: DW];
        mPtr = (w + 1) % NREQ;
        expWr = 1'b1;
`ifdef REGBANK_R0_PROTECT_EN
        expWr = (expDr != 0);
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      int a;
      check("gnt", gnt, expGnt);
      check("wr", wr, expWr);
      check("dr", dr, expDr);
      check("wrData", wrData, expData);
      check("busy", busy, |(req & ~expGnt));
      a = $urandom_range(31);
      if (mWritten[a]) check($sformatf("bank[%0d]", a), bank[a], mBank[a]);
    end
    modelStep();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(int i, logic [AW-1:0] d, logic [DW-1:0] v);
    req[i] = 1'b1;
    reqDr[i*AW +: AW] = d;
    reqData[i*DW +: DW] = v;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) setReq(i, AW'(i + 1), DW'(100 + i));
    tick();
    run = 1'b1;
    check("rst1Gnt", gnt, 0);
    check("rst1Wr", wr, 0);
    tick();
    check("rst2Gnt", gnt, 0);
    check("rst2Dr", dr, 0);
    check("rst2Data", wrData, 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rrGnt%0d", c), gnt, 64'(1) << c);
      check($sformatf("rrWr%0d", c), wr, 1);
      req &= ~gnt;
    end
    tick();
    setReq(2, 7, 32'hDEADBEEF);
    tick();
    check("oneGnt", gnt, 4'b0100);
    check("oneWr", wr, 1);
    check("oneDr", dr, 7);
    check("oneData", wrData, 32'hDEADBEEF);
    req &= ~gnt;
    tick();
    check("oneBank", bank[7], 32'hDEADBEEF);
    setReq(0, 3, 32'h30);
    setReq(3, 4, 32'h40);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("wrapGnt%0d", c), gnt, (c % 2 == 0) ? 4'b1000 : 4'b0001);
    end
    req = '0;
    tick();
    setReq(1, 9, 32'h99);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      pulses += int'(gnt[1]);
    end
    req = '0;
    check("maskPulses", pulses, 3);
    tick();
    setReq(0, 5, 10);
    setReq(1, 5, 20);
    tick();
    check("collGnt0", gnt, 4'b0001);
    req &= ~gnt;
    tick();
    check("collGnt1", gnt, 4'b0010);
    req &= ~gnt;
    tick();
    check("collBank", bank[5], 20);
    setReq(2, 0, 32'h55);
    tick();
    check("r0Gnt", gnt, 4'b0100);
`ifdef REGBANK_R0_PROTECT_EN
    check("r0Wr", wr, 0);
`else
    check("r0Wr", wr, 1);
`endif
    req &= ~gnt;
    tick();
`ifndef REGBANK_R0_PROTECT_EN
    check("r0Bank", bank[0], 32'h55);
`endif
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (req[i] && gnt[i]) begin
          req[i] = 1'b0;
          if ($urandom_range(1) == 1) setReq(i, AW'($urandom), $urandom);
        end else if (!req[i] && $urandom_range(2) == 0) setReq(i, AW'($urandom), $urandom);
      rst = ($urandom_range(200) == 0);
    end
    rst = 1'b0;
    req = '0;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
